reg_write_arbiter: RTL and testbench

- Shares the single register-file write port (wr_en/wr_reg/wr_data) between NUM_REQ writeback sources, e.g. ALU writeback and load writeback.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Registers the winning write one cycle before it reaches the register file.
- Drops writes to x0 so x0 stays zero, and exports a pending-write mask for hazard logic and a saturating contention counter.

---
 rtl/reg_write_arbiter_pkg.sv | 23 ++
 rtl/reg_write_arbiter_if.sv | 33 +++
 rtl/reg_write_arbiter_rr_arbiter.sv | 37 +++
 rtl/reg_write_arbiter.sv | 75 +++++++
 tb/tb_reg_write_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Also holds the one-hot decode used for the pending-write mask.
package reg_write_arb_pkg;

    localparam int PKG_XLEN       = 32;
    localparam int PKG_REG_ADDR_W = 5;
    localparam int NUM_REGS       = 32;

    typedef logic [PKG_REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [PKG_XLEN-1:0]       data_t;

    localparam reg_addr_t X0_ADDR = '0;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic en, input reg_addr_t addr);
        logic [NUM_REGS-1:0] mask;
        mask = '0;
        if (en) begin
            mask[addr] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester and register-file side signals of the write arbiter.
// A write transfers on a rising edge where req_valid[i] and req_ready[i] are both 1;
// req_ready never depends on anything but req_valid, rr_ptr and rst.
interface reg_write_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    import reg_write_arb_pkg::*;

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0][REG_ADDR_W-1:0] req_reg;
    logic [NUM_REQ-1:0][XLEN-1:0]       req_data;
    logic                               wr_en;
    logic [REG_ADDR_W-1:0]              wr_reg;
    logic [XLEN-1:0]                    wr_data;
    logic [NUM_REGS-1:0]                pending_mask;
    logic [CNT_W-1:0]                   conflict_cnt;
    logic                               conflict_clr;

    modport master (
        output req_valid, req_reg, req_data, conflict_clr,
        input  req_ready, wr_en, wr_reg, wr_data, pending_mask, conflict_cnt
    );

    modport slave (
        input  req_valid, req_reg, req_data, conflict_clr,
        output req_ready, wr_en, wr_reg, wr_data, pending_mask, conflict_cnt
    );

endinterface

// File: rtl/reg_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid request at or after i_rr_ptr,
// wrapping around, reported both one-hot and as an index.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_rr_ptr,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_idx
);
    import reg_write_arb_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W:0] w_idx;
    logic           w_found;

    // One extra bit on w_idx lets rr_ptr+k be wrapped by a single subtraction.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, i_rr_ptr} + (IDX_W+1)'(k);
            if (w_idx >= (IDX_W+1)'(NUM_REQ)) begin
                w_idx = w_idx - (IDX_W+1)'(NUM_REQ);
            end
            if (!w_found && i_req[w_idx[IDX_W-1:0]]) begin
                w_found                       = 1'b1;
                o_grant[w_idx[IDX_W-1:0]]     = 1'b1;
                o_grant_idx                   = w_idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin share of the register-file write port among NUM_REQ writeback sources,
// with a registered output stage, x0 suppression, pending mask and contention counter.
module reg_write_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    reg_write_arbiter_if.slave         bus,
    output logic [$clog2(NUM_REQ)-1:0] o_rr_ptr
);
    import reg_write_arb_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]      r_rr_ptr;
    logic [IDX_W-1:0]      w_grant_idx;
    logic [IDX_W-1:0]      w_ptr_next;
    logic [NUM_REQ-1:0]    w_grant;
    logic                  w_accept;
    logic                  w_conflict;
    logic [REG_ADDR_W-1:0] w_sel_reg;
    logic                  r_wr_en;
    logic [REG_ADDR_W-1:0] r_wr_reg;
    logic [XLEN-1:0]       r_wr_data;
    logic [CNT_W-1:0]      r_conflict_cnt;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .i_req       (bus.req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // Ready is masked during reset so no requester believes its write was taken.
    assign bus.req_ready = rst ? '0 : w_grant;
    assign w_accept      = ~rst & (|w_grant);
    assign w_sel_reg     = bus.req_reg[w_grant_idx];
    assign w_ptr_next    = (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
    assign w_conflict    = ($countones(bus.req_valid) >= 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_wr_en   <= 1'b0;
            r_wr_reg  <= '0;
            r_wr_data <= '0;
        end else if (w_accept) begin
            r_rr_ptr  <= w_ptr_next;
            r_wr_en   <= (w_sel_reg != REG_ADDR_W'(X0_ADDR));
            r_wr_reg  <= w_sel_reg;
            r_wr_data <= bus.req_data[w_grant_idx];
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.conflict_clr) begin
            r_conflict_cnt <= '0;
        end else if (w_conflict && (r_conflict_cnt != '1)) begin
            r_conflict_cnt <= r_conflict_cnt + 1'b1;
        end
    end

    assign bus.wr_en        = r_wr_en;
    assign bus.wr_reg       = r_wr_reg;
    assign bus.wr_data      = r_wr_data;
    assign bus.pending_mask = reg_onehot(r_wr_en, reg_addr_t'(r_wr_reg));
    assign bus.conflict_cnt = r_conflict_cnt;
    assign o_rr_ptr         = r_rr_ptr;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios then random traffic, all checked against
// a cycle-level reference model; a 4-bit-counter copy shares the stimulus for saturation.
module tb_reg_write_arbiter;

    localparam int N = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_write_arbiter_if #(.NUM_REQ(N), .XLEN(32), .REG_ADDR_W(5), .CNT_W(16)) bus ();
    reg_write_arbiter_if #(.NUM_REQ(N), .XLEN(32), .REG_ADDR_W(5), .CNT_W(4))  bus4 ();

    logic [N-1:0]        tb_valid;
    logic [N-1:0][4:0]   tb_reg;
    logic [N-1:0][31:0]  tb_data;
    logic                tb_clr;
    logic [0:0]          rr_ptr_dbg;
    logic [0:0]          rr_ptr_dbg4;

    assign bus.req_valid     = tb_valid;
    assign bus.req_reg       = tb_reg;
    assign bus.req_data      = tb_data;
    assign bus.conflict_clr  = tb_clr;
    assign bus4.req_valid    = tb_valid;
    assign bus4.req_reg      = tb_reg;
    assign bus4.req_data     = tb_data;
    assign bus4.conflict_clr = tb_clr;

    reg_write_arbiter #(.NUM_REQ(N), .XLEN(32), .REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .o_rr_ptr (rr_ptr_dbg)
    );

    reg_write_arbiter #(.NUM_REQ(N), .XLEN(32), .REG_ADDR_W(5), .CNT_W(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus4),
        .o_rr_ptr (rr_ptr_dbg4)
    );

    // Reference model state
    int          m_ptr;
    logic        m_wr_en;
    logic [4:0]  m_wr_reg;
    logic [31:0] m_wr_data;
    int          m_cnt;
    int          m_cnt4;
    int          m_last_grant;

    logic [36:0] exp_q[$];
    logic [31:0] dut_rf[32];
    logic [31:0] exp_rf[32];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (bus.wr_en) dut_rf[bus.wr_reg] <= bus.wr_data;
    end

    function automatic int model_grant();
        if (rst) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (tb_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic drive(input logic r, input logic [1:0] v, input logic [4:0] r0, input logic [31:0] d0,
                         input logic [4:0] r1, input logic [31:0] d1, input logic c);
        rst        = r;
        tb_valid   = v;
        tb_reg[0]  = r0;
        tb_data[0] = d0;
        tb_reg[1]  = r1;
        tb_data[1] = d1;
        tb_clr     = c;
    endtask

    // Called at a falling edge with inputs set; checks, crosses one rising edge, updates the model.
    task automatic step();
        int          g;
        logic [N-1:0] exp_ready;
        logic [31:0]  exp_mask;
        #1;
        g = model_grant();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        exp_mask = m_wr_en ? (32'd1 << m_wr_reg) : 32'd0;
        chk("req_ready", bus.req_ready, exp_ready);
        chk("req_ready4", bus4.req_ready, exp_ready);
        chk("wr_en", bus.wr_en, m_wr_en);
        chk("wr_reg", bus.wr_reg, m_wr_reg);
        chk("wr_data", bus.wr_data, m_wr_data);
        chk("pending_mask", bus.pending_mask, exp_mask);
        chk("conflict_cnt", bus.conflict_cnt, m_cnt);
        chk("conflict_cnt4", bus4.conflict_cnt, m_cnt4);
        chk("rr_ptr", rr_ptr_dbg, m_ptr);
        if (m_wr_en) exp_q.push_back({m_wr_reg, m_wr_data});
        if (bus.wr_en) begin
            if (exp_q.size() > 0) chk("rf_write", {bus.wr_reg, bus.wr_data}, exp_q.pop_front());
            else                  chk("rf_write_extra", bus.wr_en, 1'b0);
        end
        m_last_grant = g;
        @(posedge clk);
        if (m_wr_en) exp_rf[m_wr_reg] = m_wr_data;
        if (rst) begin
            m_ptr = 0; m_wr_en = 1'b0; m_wr_reg = '0; m_wr_data = '0; m_cnt = 0; m_cnt4 = 0;
        end else begin
            if (g >= 0) begin
                m_ptr     = (g + 1) % N;
                m_wr_reg  = tb_reg[g];
                m_wr_data = tb_data[g];
                m_wr_en   = (tb_reg[g] != 5'd0);
            end else begin
                m_wr_en = 1'b0;
            end
            if (tb_clr) begin
                m_cnt = 0; m_cnt4 = 0;
            end else if ($countones(tb_valid) >= 2) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            dut_rf[i] = '0;
            exp_rf[i] = '0;
        end
        m_ptr = 0; m_wr_en = 1'b0; m_wr_reg = '0; m_wr_data = '0;
        m_cnt = 0; m_cnt4 = 0; m_last_grant = -1;
        drive(1'b1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);

        // Reset held with both requesters valid
        drive(1'b1, 2'b11, 5'd3, 32'h1, 5'd4, 32'h2, 1'b0);
        repeat (2) begin
            #1 chk("rst_ready", bus.req_ready, 2'b00);
            step();
        end
        drive(1'b0, 2'b11, 5'd3, 32'h1, 5'd4, 32'h2, 1'b0);
        #1 chk("release_ready", bus.req_ready, 2'b01);
        drive(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        step();

        // Single write from requester 0
        drive(1'b0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 1'b0);
        #1 chk("single_ready", bus.req_ready, 2'b01);
        step();
        drive(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        #1;
        chk("single_wr_en", bus.wr_en, 1'b1);
        chk("single_wr_reg", bus.wr_reg, 5'd5);
        chk("single_wr_data", bus.wr_data, 32'hDEADBEEF);
        chk("single_mask", bus.pending_mask, 32'h20);
        step();
        #1 chk("single_done", bus.wr_en, 1'b0);

        // Write to x0 from requester 1 is accepted then dropped
        drive(1'b0, 2'b10, 5'd0, 32'd0, 5'd0, 32'hFFFFFFFF, 1'b0);
        #1 chk("x0_ready", bus.req_ready, 2'b10);
        step();
        drive(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        #1;
        chk("x0_wr_en", bus.wr_en, 1'b0);
        chk("x0_mask", bus.pending_mask, 32'h0);
        chk("x0_rr_ptr", rr_ptr_dbg, 1'b0);
        step();

        // Contention: grants alternate, no bubble on the write port
        drive(1'b0, 2'b11, 5'd1, 32'h11, 5'd2, 32'h22, 1'b0);
        for (int k = 0; k < 4; k++) begin
            logic [1:0] e_rdy;
            e_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1 chk("cont_grant", bus.req_ready, e_rdy);
            if (k > 0) chk("cont_wr_reg", bus.wr_reg, ((k - 1) % 2 == 0) ? 5'd1 : 5'd2);
            step();
        end
        drive(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        #1;
        chk("cont_last_reg", bus.wr_reg, 5'd2);
        chk("cont_cnt", bus.conflict_cnt, 16'd4);
        step();

        // Reset arriving while a write sits in the output stage
        drive(1'b0, 2'b01, 5'd7, 32'h77, 5'd0, 32'd0, 1'b0);
        step();
        drive(1'b1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        #1 chk("rstmid_staged", bus.wr_en, 1'b1);
        step();
        drive(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        #1;
        chk("rstmid_wr_en", bus.wr_en, 1'b0);
        chk("rstmid_mask", bus.pending_mask, 32'h0);
        step();

        // Saturation of the 4-bit counter, then clear beating a conflict
        drive(1'b0, 2'b11, 5'd3, 32'h33, 5'd4, 32'h44, 1'b1);
        step();
        drive(1'b0, 2'b11, 5'd3, 32'h33, 5'd4, 32'h44, 1'b0);
        #1 chk("clr_cnt4", bus4.conflict_cnt, 4'd0);
        repeat (20) step();
        #1;
        chk("sat_cnt4", bus4.conflict_cnt, 4'd15);
        chk("cnt16_20", bus.conflict_cnt, 16'd20);
        drive(1'b0, 2'b11, 5'd3, 32'h33, 5'd4, 32'h44, 1'b1);
        step();
        drive(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        #1;
        chk("clr_wins4", bus4.conflict_cnt, 4'd0);
        chk("clr_wins16", bus.conflict_cnt, 16'd0);
        step();

        // Random traffic; a stalled requester keeps its request stable
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(tb_valid[i] && m_last_grant != i)) begin
                    tb_valid[i] = ($urandom_range(0, 3) != 0);
                    tb_reg[i]   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    tb_data[i]  = $urandom();
                end
            end
            rst    = ($urandom_range(0, 59) == 0);
            tb_clr = ($urandom_range(0, 29) == 0);
            step();
        end

        drive(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        repeat (2) step();
        for (int i = 0; i < 32; i++) chk($sformatf("rf_x%0d", i), dut_rf[i], exp_rf[i]);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
